// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported RAM between the instruction-fetch port
//             and the data port of a processor core.
//             - Fetches, loads and stores are captured into one slot per port.
//             - The captured requests are serialized onto one req/ack RAM port.
//             - Each requester gets its own read-response pulse.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             imem_*            - fetch port (16-bit address, valid pulse)
//             mem_*             - data port (load/store, ready, valid pulse)
//             ram_*             - downstream request/acknowledge RAM port
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter logic [31:0] IBASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] imem_addr,
    input  logic        imem_oe,
    output logic [31:0] imem_rdata,
    output logic        imem_valid,
    input  logic [31:0] mem_addr,
    input  logic        mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_ready,
    output logic        ram_req,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic        ram_rvalid,
    input  logic [31:0] ram_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        lastgnt_q, lastgnt_d;
    logic        ipend_q, ipend_d;
    logic [15:0] iaddr_q, iaddr_d;
    logic        istale_q, istale_d;
    logic        dpend_q, dpend_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [3:0]  dwe_q, dwe_d;
    logic        ram_req_q, ram_req_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [3:0]  ram_we_q, ram_we_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;

    logic        w_idle;
    logic        w_dcap;
    logic        w_icand;
    logic        w_dcand;
    logic        w_gnt_d;
    logic        w_gnt_i;
    logic        w_ack;
    logic        w_iresp;
    logic        w_ifly;

    assign w_idle  = (state_q == S_IDLE);
    assign w_dcap  = mem_oe & mem_ready;
    // Same-cycle strobes join the candidate set so an idle arbiter issues them
    // directly without first parking them in a slot.
    assign w_icand = ipend_q | imem_oe;
    assign w_dcand = dpend_q | w_dcap;
    // On a tie the port that did not win last time is served.
    assign w_gnt_d = w_idle & w_dcand & (~w_icand | (lastgnt_q == OWN_I));
    assign w_gnt_i = w_idle & w_icand & ~w_gnt_d;
    assign w_ack   = ram_req_q & ram_ack;
    assign w_iresp = ram_rvalid & (state_q == S_RESP) & (owner_q == OWN_I);
    assign w_ifly  = ~w_idle & (owner_q == OWN_I);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_icand | w_dcand) state_d = S_ISSUE;
            S_ISSUE: if (w_ack) state_d = (ram_we_q != 4'd0) ? S_IDLE : S_RESP;
            S_RESP:  if (ram_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_ready  = ~dpend_q & ~((owner_q == OWN_D) & ~w_idle);
        mem_valid  = ram_rvalid & (state_q == S_RESP) & (owner_q == OWN_D);
        // A fetch arriving in the response cycle supersedes the one answered.
        imem_valid = w_iresp & ~istale_q & ~imem_oe;
    end

    assign imem_rdata = ram_rdata;
    assign mem_rdata  = ram_rdata;
    assign ram_req    = ram_req_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;

    // ------------------------------------------------------------------
    // Capture slots and downstream request fields
    // ------------------------------------------------------------------
    always_comb begin
        owner_d     = owner_q;
        lastgnt_d   = lastgnt_q;
        ipend_d     = ipend_q;
        iaddr_d     = iaddr_q;
        istale_d    = istale_q;
        dpend_d     = dpend_q;
        daddr_d     = daddr_q;
        dwdata_d    = dwdata_q;
        dwe_d       = dwe_q;
        ram_req_d   = ram_req_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        ram_wdata_d = ram_wdata_q;

        // Newest fetch always wins the slot, overwriting an unissued one.
        if (imem_oe) begin
            ipend_d = 1'b1;
            iaddr_d = imem_addr;
        end
        if (w_gnt_i) begin
            ipend_d = 1'b0;
        end

        // The in-flight fetch's response ends any staleness; otherwise a new
        // fetch during an in-flight fetch makes that fetch's data unwanted.
        if (w_iresp) begin
            istale_d = 1'b0;
        end else if (imem_oe & w_ifly) begin
            istale_d = 1'b1;
        end

        if (w_dcap) begin
            dpend_d  = 1'b1;
            daddr_d  = mem_addr;
            dwdata_d = mem_wdata;
            dwe_d    = mem_we;
        end
        if (w_gnt_d) begin
            dpend_d = 1'b0;
        end

        if (w_gnt_d) begin
            ram_req_d   = 1'b1;
            ram_addr_d  = dpend_q ? daddr_q  : mem_addr;
            ram_we_d    = dpend_q ? dwe_q    : mem_we;
            ram_wdata_d = dpend_q ? dwdata_q : mem_wdata;
            owner_d     = OWN_D;
            lastgnt_d   = OWN_D;
        end else if (w_gnt_i) begin
            ram_req_d   = 1'b1;
            ram_addr_d  = IBASE | {16'h0000, (imem_oe ? imem_addr : iaddr_q)};
            ram_we_d    = 4'd0;
            ram_wdata_d = 32'd0;
            owner_d     = OWN_I;
            lastgnt_d   = OWN_I;
        end else if (w_ack) begin
            ram_req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_I;
            lastgnt_q   <= OWN_I;
            ipend_q     <= 1'b0;
            iaddr_q     <= 16'd0;
            istale_q    <= 1'b0;
            dpend_q     <= 1'b0;
            daddr_q     <= 32'd0;
            dwdata_q    <= 32'd0;
            dwe_q       <= 4'd0;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_we_q    <= 4'd0;
            ram_wdata_q <= 32'd0;
        end else begin
            owner_q     <= owner_d;
            lastgnt_q   <= lastgnt_d;
            ipend_q     <= ipend_d;
            iaddr_q     <= iaddr_d;
            istale_q    <= istale_d;
            dpend_q     <= dpend_d;
            daddr_q     <= daddr_d;
            dwdata_q    <= dwdata_d;
            dwe_q       <= dwe_d;
            ram_req_q   <= ram_req_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios
//             followed by randomized fetch/data traffic against a RAM stub;
//             expected responses are queued at issue time and checked by an
//             independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [31:0] IBASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr = '0;
    logic        imem_oe = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] mem_addr = '0;
    logic        mem_oe = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_we = '0;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        ram_req;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic        ram_ack = 1'b0;
    logic        ram_rvalid = 1'b0;
    logic [31:0] ram_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.IBASE(IBASE)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_oe(imem_oe), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference memory (core's view) and RAM stub memory.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function logic [31:0] ram_read(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    // Scoreboard queues: fetch queue holds at most the newest fetch.
    logic [31:0] dq[$];
    logic [31:0] iq[$];
    int          dstreak = 0;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- Monitor ----------------
    initial begin
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        logic [3:0]  prev_we;
        prev_req = 0; prev_ack = 0; prev_addr = 0; prev_wdata = 0; prev_we = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 0;
                prev_ack = 0;
                dstreak  = 0;
            end else begin
                if (mem_valid) begin
                    if (dq.size() == 0) chk("mem_valid_unexpected", 32'(mem_valid), 32'd0);
                    else chk("load_data", mem_rdata, dq.pop_front());
                end
                if (imem_valid) begin
                    if (iq.size() == 0) chk("imem_valid_unexpected", 32'(imem_valid), 32'd0);
                    else chk("fetch_data", imem_rdata, iq.pop_front());
                end
                if (prev_req && !prev_ack) begin
                    chk("ram_req_held", 32'(ram_req), 32'd1);
                    chk("ram_addr_stable", ram_addr, prev_addr);
                    chk("ram_we_stable", 32'(ram_we), 32'(prev_we));
                    chk("ram_wdata_stable", ram_wdata, prev_wdata);
                end
                if (ram_req && !prev_req) begin
                    if (ram_addr[31]) begin
                        dstreak = 0;
                    end else if (iq.size() != 0) begin
                        dstreak++;
                        chk("fetch_wait_le_one_data_grant", (dstreak <= 1) ? 32'd1 : 32'd0, 32'd1);
                    end
                end
                prev_req   = ram_req;
                prev_ack   = ram_ack;
                prev_addr  = ram_addr;
                prev_wdata = ram_wdata;
                prev_we    = ram_we;
            end
        end
    end

    // ---------------- RAM stub (active only in random phase) ----------------
    logic        ram_auto = 1'b0;
    logic        rd_pend = 1'b0;
    int          rd_dly = 0;
    logic [31:0] rd_data = '0;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ram_auto) begin
                ram_ack    = 1'b0;
                ram_rvalid = 1'b0;
                ram_rdata  = $urandom;
                if (rst) begin
                    rd_pend = 1'b0;
                end else if (rd_pend) begin
                    if (rd_dly == 0) begin
                        ram_rvalid = 1'b1;
                        ram_rdata  = rd_data;
                        rd_pend    = 1'b0;
                    end else begin
                        rd_dly--;
                    end
                end else if (ram_req) begin
                    if ($urandom_range(0, 99) < 55) begin
                        ram_ack = 1'b1;
                        if (ram_we != 4'd0) begin
                            ram_mem[ram_addr] = merge(ram_read(ram_addr), ram_wdata, ram_we);
                        end else begin
                            rd_pend = 1'b1;
                            rd_dly  = $urandom_range(0, 3);
                            rd_data = ram_read(ram_addr);
                        end
                    end
                end else begin
                    // Stray strobes while idle must be ignored by the DUT.
                    ram_ack    = ($urandom_range(0, 9) == 0);
                    ram_rvalid = ($urandom_range(0, 9) == 0);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the capture edge.
    task automatic data_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int g;
        g = 0;
        while (!mem_ready && g < 400) begin
            cyc();
            g++;
        end
        if (g >= 400) chk("mem_ready_timeout", g, 32'd0);
        mem_oe = 1'b1; mem_addr = a; mem_wdata = d; mem_we = be;
        if (be == 4'd0) dq.push_back(ref_read(a));
        else ref_mem[a] = merge(ref_read(a), d, be);
        cyc();
        mem_oe = 1'b0; mem_we = 4'd0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, dq=%0d iq=%0d", dq.size(), iq.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        // ---- reset values ----
        smp();
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_imem_valid", 32'(imem_valid), 32'd0);
        cyc(); cyc();
        rst = 1'b0;

        // ---- single load, best case ----
        mem_oe = 1'b1; mem_addr = 32'h100; mem_we = 4'd0;
        dq.push_back(32'hDEAD_BEEF);
        smp(); chk("load_c0_ready", 32'(mem_ready), 32'd1);
        cyc(); mem_oe = 1'b0; ram_ack = 1'b1;
        smp();
        chk("load_c1_req", 32'(ram_req), 32'd1);
        chk("load_c1_addr", ram_addr, 32'h100);
        chk("load_c1_ready", 32'(mem_ready), 32'd0);
        cyc(); ram_ack = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        smp();
        chk("load_c2_valid", 32'(mem_valid), 32'd1);
        chk("load_c2_ready", 32'(mem_ready), 32'd0);
        cyc(); ram_rvalid = 1'b0;
        smp();
        chk("load_c3_ready", 32'(mem_ready), 32'd1);
        chk("load_c3_req", 32'(ram_req), 32'd0);

        // ---- store with ack backpressure ----
        cyc(); mem_oe = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h1234; mem_we = 4'b0011;
        cyc(); mem_oe = 1'b0; mem_we = 4'd0;
        for (int k = 0; k < 4; k++) begin
            ram_ack = (k == 3);
            smp();
            chk("store_req", 32'(ram_req), 32'd1);
            chk("store_addr", ram_addr, 32'h40);
            chk("store_we", 32'(ram_we), 32'h3);
            chk("store_wdata", ram_wdata, 32'h1234);
            chk("store_ready_low", 32'(mem_ready), 32'd0);
            cyc();
        end
        ram_ack = 1'b0;
        smp();
        chk("store_done_req", 32'(ram_req), 32'd0);
        chk("store_done_ready", 32'(mem_ready), 32'd1);

        // ---- tie after reset: data first, then fetch ----
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        imem_oe = 1'b1; imem_addr = 16'h0010; iq.delete(); iq.push_back(32'h2222_2222); dstreak = 0;
        mem_oe = 1'b1; mem_addr = 32'h200; mem_we = 4'd0; dq.push_back(32'h1111_1111);
        cyc(); imem_oe = 1'b0; mem_oe = 1'b0; ram_ack = 1'b1;
        smp();
        chk("tie_first_req", 32'(ram_req), 32'd1);
        chk("tie_first_addr", ram_addr, 32'h200);
        cyc(); ram_ack = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h1111_1111;
        smp();
        chk("tie_d_valid", 32'(mem_valid), 32'd1);
        chk("tie_d_no_ivalid", 32'(imem_valid), 32'd0);
        cyc(); ram_rvalid = 1'b0;
        smp(); chk("tie_gap", 32'(ram_req), 32'd0);
        cyc(); ram_ack = 1'b1;
        smp();
        chk("tie_second_req", 32'(ram_req), 32'd1);
        chk("tie_second_addr", ram_addr, IBASE | 32'h10);
        cyc(); ram_ack = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h2222_2222;
        smp();
        chk("tie_i_valid", 32'(imem_valid), 32'd1);
        chk("tie_i_no_dvalid", 32'(mem_valid), 32'd0);
        cyc(); ram_rvalid = 1'b0;

        // ---- stale fetch ----
        imem_oe = 1'b1; imem_addr = 16'h0004; iq.delete(); iq.push_back(32'h4444_4444); dstreak = 0;
        cyc(); imem_oe = 1'b0; ram_ack = 1'b1;
        smp(); chk("stale_first_addr", ram_addr, IBASE | 32'h4);
        cyc(); ram_ack = 1'b0;
        imem_oe = 1'b1; imem_addr = 16'h0008; iq.delete(); iq.push_back(32'h8888_8888); dstreak = 0;
        cyc(); imem_oe = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h0BAD_0004;
        smp(); chk("stale_swallowed", 32'(imem_valid), 32'd0);
        cyc(); ram_rvalid = 1'b0;
        smp(); chk("stale_gap", 32'(ram_req), 32'd0);
        cyc(); ram_ack = 1'b1;
        smp();
        chk("stale_reissue_req", 32'(ram_req), 32'd1);
        chk("stale_reissue_addr", ram_addr, IBASE | 32'h8);
        cyc(); ram_ack = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h8888_8888;
        smp(); chk("stale_new_valid", 32'(imem_valid), 32'd1);
        cyc(); ram_rvalid = 1'b0;

        // ---- reset while a load waits in RESP ----
        mem_oe = 1'b1; mem_addr = 32'h300; mem_we = 4'd0;
        cyc(); mem_oe = 1'b0; ram_ack = 1'b1;
        cyc(); ram_ack = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_req", 32'(ram_req), 32'd0);
        chk("midrst_addr", ram_addr, 32'd0);
        chk("midrst_ready", 32'(mem_ready), 32'd1);
        chk("midrst_mvalid", 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'h3333_3333;
        smp();
        chk("late_rvalid_mvalid", 32'(mem_valid), 32'd0);
        chk("late_rvalid_ivalid", 32'(imem_valid), 32'd0);
        chk("late_rvalid_ready", 32'(mem_ready), 32'd1);
        chk("late_rvalid_req", 32'(ram_req), 32'd0);
        cyc(); ram_rvalid = 1'b0;

        // ---- randomized traffic ----
        rst = 1'b1;
        cyc(); rst = 1'b0; ram_auto = 1'b1;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    logic [31:0] a;
                    logic [31:0] d;
                    logic [3:0]  be;
                    repeat ($urandom_range(0, 3)) cyc();
                    a  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    d  = $urandom;
                    data_op(a, d, be);
                end
            end
            begin
                for (int n = 0; n < 120; n++) begin
                    logic [15:0] fa;
                    repeat ($urandom_range(0, 9)) cyc();
                    fa = 16'($urandom);
                    imem_oe = 1'b1; imem_addr = fa;
                    iq.delete(); iq.push_back(init_word(IBASE | {16'h0000, fa}));
                    dstreak = 0;
                    cyc();
                    imem_oe = 1'b0;
                end
            end
        join

        w = 0;
        while ((dq.size() != 0 || iq.size() != 0) && w < 400) begin
            cyc();
            w++;
        end
        chk("loads_drained", dq.size(), 32'd0);
        chk("fetch_drained", iq.size(), 32'd0);
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
